// File: rtl/shift_right_seq.sv
// Round-robin sequencer for the 10x5-bit lane shifter: a job is split into passes of at most 4 lanes.
// Optional SHIFT_RIGHT_SEQ_BYPASS_EN: amounts of NLANES or more load all-fill and complete in one cycle.

module shift_right_seq_lanes #(
   parameter int WIDTH  = 50,
   parameter int LANE_W = 5,
   parameter int NLANES = 10
) (
   input  logic [WIDTH-1:0]  din,
   input  logic [2:0]        sel,
   input  logic [LANE_W-1:0] fill,
   output logic [WIDTH-1:0]  dout,
   output logic              ok
);
   // Lane k takes lane k+sel; lanes shifted in from above the top take the fill pattern.
   always_comb begin
      dout = '0;
      for (int k = 0; k < NLANES; k++) begin
         if (k + int'(sel) < NLANES) begin
            dout[k*LANE_W +: LANE_W] = din[(k + int'(sel))*LANE_W +: LANE_W];
         end else begin
            dout[k*LANE_W +: LANE_W] = fill;
         end
      end
   end

   assign ok = (sel <= 3'd4);
endmodule

module shift_right_seq_chk (
   input logic clk,
   input logic rst,
   input logic in_run,
   input logic shift_ok
);
   shift_sel_in_range: assert property (@(posedge clk) disable iff (rst) in_run |-> shift_ok);
endmodule

module shift_right_seq #(
   parameter int WIDTH  = 50,
   parameter int LANE_W = 5,
   parameter int NLANES = 10,
   parameter int AMT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_data,
   input  logic [AMT_W-1:0]  req0_amt,
   input  logic [LANE_W-1:0] req0_fill,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_data,
   input  logic [AMT_W-1:0]  req1_amt,
   input  logic [LANE_W-1:0] req1_fill,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              rsp_id,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t              state_r, state_s;
   logic [WIDTH-1:0]    work_r;
   logic [AMT_W-1:0]    rem_r;
   logic [LANE_W-1:0]   fill_r;
   logic                id_r, last_grant_r, rsp_valid_r, busy_r;
   logic                grant0_s, grant1_s, accept_s, bypass_s;
   logic [WIDTH-1:0]    acc_data_s, shifted_s;
   logic [AMT_W-1:0]    acc_amt_s, rem_next_s;
   logic [LANE_W-1:0]   acc_fill_s;
   logic [2:0]          step_s;
   logic                shift_ok_s;

   // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
   always_comb begin
      grant0_s = (state_r == IDLE) && req0_valid && (!req1_valid || last_grant_r);
      grant1_s = (state_r == IDLE) && req1_valid && (!req0_valid || !last_grant_r);
      accept_s = grant0_s || grant1_s;
      if (grant1_s) begin
         acc_data_s = req1_data;
         acc_amt_s  = req1_amt;
         acc_fill_s = req1_fill;
      end else begin
         acc_data_s = req0_data;
         acc_amt_s  = req0_amt;
         acc_fill_s = req0_fill;
      end
`ifdef SHIFT_RIGHT_SEQ_BYPASS_EN
      bypass_s = accept_s && (acc_amt_s >= AMT_W'(NLANES));
`else
      bypass_s = 1'b0;
`endif
      step_s     = (rem_r > AMT_W'(4)) ? 3'd4 : rem_r[2:0];
      rem_next_s = rem_r - AMT_W'(step_s);
   end

   shift_right_seq_lanes #(.WIDTH(WIDTH), .LANE_W(LANE_W), .NLANES(NLANES)) u_lanes (
      .din  (work_r),
      .sel  (step_s),
      .fill (fill_r),
      .dout (shifted_s),
      .ok   (shift_ok_s)
   );

   shift_right_seq_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .in_run   (state_r == RUN),
      .shift_ok (shift_ok_s)
   );

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && ((acc_amt_s == AMT_W'(0)) || bypass_s)) begin
               state_s = DONE;
            end else if (accept_s) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (rem_next_s == AMT_W'(0)) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Job registers, one shifter pass per RUN cycle, and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         work_r       <= '0;
         rem_r        <= '0;
         fill_r       <= '0;
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
         rsp_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         rsp_valid_r <= (state_s == DONE);
         busy_r      <= (state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  work_r       <= bypass_s ? {NLANES{acc_fill_s}} : acc_data_s;
                  rem_r        <= acc_amt_s;
                  fill_r       <= acc_fill_s;
                  id_r         <= grant1_s;
                  last_grant_r <= grant1_s;
               end
            end
            RUN: begin
               work_r <= shifted_s;
               rem_r  <= rem_next_s;
            end
            default: begin
            end
         endcase
      end
   end

   assign req0_ready = grant0_s;
   assign req1_ready = grant1_s;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_data   = work_r;
   assign rsp_id     = id_r;
   assign busy       = busy_r;
endmodule
